// File: rtl/rf_writeback_queue.sv
// rf_writeback_queue: write-side front end for the register file.
// Merges single-cycle ALU results (source A, top priority, no back-pressure)
// with long-latency results (source B, in-order queue behind valid/ready)
// into one registered write port, and exports a per-register pending mask.
// A younger A write kills any queued B entry that targets the same register.
// Optional feature macro: WBQ_STATS_EN adds a saturating kill_count output.
module rf_writeback_queue #(
    parameter int Nloc  = 32,
    parameter int Dbits = 32,
    parameter int Depth = 4,
    localparam int AW = $clog2(Nloc),
    localparam int CW = $clog2(Depth) + 1,
    localparam int IW = $clog2(Depth)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             a_valid,
    input  logic [AW-1:0]    a_addr,
    input  logic [Dbits-1:0] a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [AW-1:0]    b_addr,
    input  logic [Dbits-1:0] b_data,
    output logic             wr,
    output logic [AW-1:0]    WriteAddr,
    output logic [Dbits-1:0] WriteData,
    output logic [Nloc-1:0]  pending_mask,
    output logic [CW-1:0]    count
`ifdef WBQ_STATS_EN
    ,
    output logic [15:0]      kill_count
`endif
);

    logic [AW-1:0]    addrQ    [Depth];
    logic [Dbits-1:0] dataQ    [Depth];
    logic [AW-1:0]    addrNext [Depth];
    logic [Dbits-1:0] dataNext [Depth];
    logic [CW-1:0]    fill;
    logic [CW-1:0]    killNum;
    logic             aIssue;
    logic             bAccept;
    logic             pop;

    // Writes to register 0 are meaningless, so A to r0 behaves as no A at all
    assign aIssue  = a_valid && (a_addr != '0);
    assign b_ready = enable && (count < CW'(Depth));
    assign bAccept = b_valid && b_ready && (b_addr != '0);
    assign pop     = !aIssue && (count != '0);

    // Build the next queue image: drop killed entries and the popped head,
    // keep survivors in order, then append the accepted push unless A kills it
    always_comb begin
        fill    = '0;
        killNum = '0;
        for (int i = 0; i < Depth; i++) begin
            addrNext[i] = addrQ[i];
            dataNext[i] = dataQ[i];
        end
        for (int i = 0; i < Depth; i++) begin
            if (CW'(i) < count) begin
                if (aIssue && (addrQ[i] == a_addr)) begin
                    killNum = killNum + CW'(1);
                end else if (!(pop && (i == 0))) begin
                    addrNext[fill[IW-1:0]] = addrQ[i];
                    dataNext[fill[IW-1:0]] = dataQ[i];
                    fill = fill + CW'(1);
                end
            end
        end
        if (bAccept) begin
            if (aIssue && (b_addr == a_addr)) begin
                killNum = killNum + CW'(1);
            end else if (fill < CW'(Depth)) begin
                addrNext[fill[IW-1:0]] = b_addr;
                dataNext[fill[IW-1:0]] = b_data;
                fill = fill + CW'(1);
            end
        end
    end

    // Mark every register that still has a live queued write heading to it
    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < Depth; i++) begin
            if (CW'(i) < count) begin
                pending_mask[addrQ[i]] = 1'b1;
            end
        end
        pending_mask[0] = 1'b0;
    end

    // Queue storage and occupancy advance only while enabled
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            for (int i = 0; i < Depth; i++) begin
                addrQ[i] <= '0;
                dataQ[i] <= '0;
            end
        end else if (enable) begin
            count <= fill;
            for (int i = 0; i < Depth; i++) begin
                addrQ[i] <= addrNext[i];
                dataQ[i] <= dataNext[i];
            end
        end
    end

    // Output register: A first, else queue head, else idle with address/data held
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr        <= 1'b0;
            WriteAddr <= '0;
            WriteData <= '0;
        end else if (enable) begin
            if (aIssue) begin
                wr        <= 1'b1;
                WriteAddr <= a_addr;
                WriteData <= a_data;
            end else if (pop) begin
                wr        <= 1'b1;
                WriteAddr <= addrQ[0];
                WriteData <= dataQ[0];
            end else begin
                wr        <= 1'b0;
            end
        end
    end

`ifdef WBQ_STATS_EN
    logic [16:0] killSum;
    assign killSum = {1'b0, kill_count} + 17'(killNum);

    // Saturating tally of queue entries discarded by younger A writes
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            kill_count <= '0;
        end else if (enable) begin
            kill_count <= killSum[16] ? 16'hFFFF : killSum[15:0];
        end
    end
`else
    logic unusedKillNum;
    assign unusedKillNum = ^killNum;
`endif

endmodule

// File: tb/tb_rf_writeback_queue.sv
// tb_rf_writeback_queue: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model.
// Build with WBQ_STATS_EN defined to also check kill_count.
module tb_rf_writeback_queue;

    localparam int Nloc  = 32;
    localparam int Dbits = 32;
    localparam int Depth = 4;
    localparam int AW    = 5;
    localparam int CW    = 3;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             enable;
    logic             a_valid;
    logic [AW-1:0]    a_addr;
    logic [Dbits-1:0] a_data;
    logic             b_valid;
    logic             b_ready;
    logic [AW-1:0]    b_addr;
    logic [Dbits-1:0] b_data;
    logic             wr;
    logic [AW-1:0]    WriteAddr;
    logic [Dbits-1:0] WriteData;
    logic [Nloc-1:0]  pending_mask;
    logic [CW-1:0]    count;
`ifdef WBQ_STATS_EN
    logic [15:0]      kill_count;
`endif

    rf_writeback_queue #(.Nloc(Nloc), .Dbits(Dbits), .Depth(Depth)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .enable       (enable),
        .a_valid      (a_valid),
        .a_addr       (a_addr),
        .a_data       (a_data),
        .b_valid      (b_valid),
        .b_ready      (b_ready),
        .b_addr       (b_addr),
        .b_data       (b_data),
        .wr           (wr),
        .WriteAddr    (WriteAddr),
        .WriteData    (WriteData),
        .pending_mask (pending_mask),
        .count        (count)
`ifdef WBQ_STATS_EN
        ,
        .kill_count   (kill_count)
`endif
    );

    // Free-running clock, period 10
    always #5 clock = ~clock;

    typedef struct packed {
        logic [AW-1:0]    addr;
        logic [Dbits-1:0] data;
    } entry_t;

    entry_t           modelQ[$];
    logic             mWr;
    logic [AW-1:0]    mAddr;
    logic [Dbits-1:0] mData;
    int               mKills;
    bit               mAccepted;
    int               testsRun    = 0;
    int               testsFailed = 0;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        modelQ.delete();
        mWr       = 1'b0;
        mAddr     = '0;
        mData     = '0;
        mKills    = 0;
        mAccepted = 1'b0;
    endtask

    // Compare every DUT output with what the model says should be visible now
    task automatic checkOutput(input string ctx);
        logic [Nloc-1:0] expMask;
        logic            expReady;
        expMask = '0;
        foreach (modelQ[i]) expMask[modelQ[i].addr] = 1'b1;
        expMask[0] = 1'b0;
        expReady = enable && (modelQ.size() < Depth);
        checkVal({ctx, ".wr"},        64'(wr),           64'(mWr));
        checkVal({ctx, ".addr"},      64'(WriteAddr),    64'(mAddr));
        checkVal({ctx, ".data"},      64'(WriteData),    64'(mData));
        checkVal({ctx, ".count"},     64'(count),        64'(modelQ.size()));
        checkVal({ctx, ".mask"},      64'(pending_mask), 64'(expMask));
        checkVal({ctx, ".b_ready"},   64'(b_ready),      64'(expReady));
`ifdef WBQ_STATS_EN
        checkVal({ctx, ".kills"},     64'(kill_count),   64'(mKills));
`endif
    endtask

    // One enabled edge from the reference point of view: A wins, kills
    // matching queued writes, otherwise the oldest queued write drains
    task automatic modelStep();
        bit     aIss;
        bit     acc;
        entry_t e;
        mAccepted = 1'b0;
        if (!enable) return;
        aIss = a_valid && (a_addr != 0);
        acc  = b_valid && (modelQ.size() < Depth);
        mAccepted = acc;
        if (aIss) begin
            mWr   = 1'b1;
            mAddr = a_addr;
            mData = a_data;
            for (int i = modelQ.size() - 1; i >= 0; i--) begin
                if (modelQ[i].addr == a_addr) begin
                    modelQ.delete(i);
                    mKills++;
                end
            end
            if (acc && b_addr != 0) begin
                if (b_addr == a_addr) mKills++;
                else modelQ.push_back({b_addr, b_data});
            end
        end else begin
            if (modelQ.size() > 0) begin
                e     = modelQ.pop_front();
                mWr   = 1'b1;
                mAddr = e.addr;
                mData = e.data;
            end else begin
                mWr = 1'b0;
            end
            if (acc && b_addr != 0) modelQ.push_back({b_addr, b_data});
        end
        if (mKills > 65535) mKills = 65535;
    endtask

    task automatic applyStimulus(input bit en, input bit av, input logic [AW-1:0] aa,
                                 input logic [Dbits-1:0] ad, input bit bv,
                                 input logic [AW-1:0] ba, input logic [Dbits-1:0] bd,
                                 input string tag);
        @(negedge clock);
        enable  = en;
        a_valid = av;
        a_addr  = aa;
        a_data  = ad;
        b_valid = bv;
        b_addr  = ba;
        b_data  = bd;
        #1;
        checkOutput(tag);
        modelStep();
    endtask

    task automatic idleInputs();
        a_valid = 1'b0;
        a_addr  = '0;
        a_data  = '0;
        b_valid = 1'b0;
        b_addr  = '0;
        b_data  = '0;
    endtask

    initial begin
        reset_n = 1'b1;
        enable  = 1'b1;
        idleInputs();
        modelReset();
        #2 reset_n = 1'b0;
        #1;
        checkOutput("reset");
        enable = 1'b0;
        #1;
        checkOutput("reset_en0");
        enable = 1'b1;
        @(negedge clock);
        reset_n = 1'b1;

        // B only: r5 goes through the empty queue
        applyStimulus(1, 0, 0, 0, 1, 5, 32'hDEADBEEF, "bonly.push");
        repeat (3) applyStimulus(1, 0, 0, 0, 0, 0, 0, "bonly.idle");

        // Priority: fill r3, r4 behind A traffic, then A r7 twice
        applyStimulus(1, 1, 20, 32'h14, 1, 3, 32'h33, "prio.push3");
        applyStimulus(1, 1, 21, 32'h15, 1, 4, 32'h44, "prio.push4");
        applyStimulus(1, 1, 7,  32'h70, 0, 0, 0,      "prio.a7a");
        applyStimulus(1, 1, 7,  32'h71, 0, 0, 0,      "prio.a7b");
        repeat (3) applyStimulus(1, 0, 0, 0, 0, 0, 0, "prio.drain");

        // WAW kill: r9=1, r10=2 queued, then A writes r9=3
        applyStimulus(1, 1, 21, 32'h15, 1, 9,  32'h1, "waw.push9");
        applyStimulus(1, 1, 22, 32'h16, 1, 10, 32'h2, "waw.push10");
        applyStimulus(1, 1, 9,  32'h3,  0, 0,  0,     "waw.a9");
        repeat (3) applyStimulus(1, 0, 0, 0, 0, 0, 0, "waw.drain");

        // Same-cycle push killed by A to the same register
        applyStimulus(1, 1, 12, 32'hA12, 1, 12, 32'hB12, "samekill");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, "samekill.idle");

        // Full queue with continuous A, fifth offer held off until a pop
        for (int i = 0; i < 4; i++)
            applyStimulus(1, 1, 22, 32'h100 + i, 1, AW'(11 + i), 32'h200 + i, "full.push");
        applyStimulus(1, 1, 23, 32'h300, 1, 15, 32'h215, "full.blocked");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 0, 0, 0, 1, 15, 32'h215, "full.retry");
            if (mAccepted) break;
        end
        repeat (6) applyStimulus(1, 0, 0, 0, 0, 0, 0, "full.drain");

        // Register 0 on both sources
        applyStimulus(1, 1, 0, 32'hF00, 1, 0, 32'hF01, "r0");
        repeat (2) applyStimulus(1, 0, 0, 0, 0, 0, 0, "r0.idle");

        // Enable freeze while a write is pending
        applyStimulus(1, 1, 6, 32'h1234, 1, 8, 32'h5678, "freeze.go");
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 1, AW'(i + 1), 32'hBAD0 + i, 1, 17, 32'hBAD, "freeze.hold");
        repeat (3) applyStimulus(1, 0, 0, 0, 0, 0, 0, "freeze.resume");

        // Asynchronous reset in the middle of a cycle
        applyStimulus(1, 1, 24, 32'h24, 1, 18, 32'h18, "async.fill");
        applyStimulus(1, 1, 25, 32'h25, 1, 19, 32'h19, "async.fill2");
        @(negedge clock);
        idleInputs();
        #1 reset_n = 1'b0;
        #1;
        modelReset();
        checkVal("async.wr",    64'(wr),           64'(0));
        checkVal("async.count", 64'(count),        64'(0));
        checkVal("async.mask",  64'(pending_mask), 64'(0));
        @(negedge clock);
        reset_n = 1'b1;

        // Random traffic over a small register range to provoke kills
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 9) != 0,
                          $urandom_range(0, 9) < 4, AW'($urandom_range(0, 7)), $urandom(),
                          $urandom_range(0, 9) < 6, AW'($urandom_range(0, 7)), $urandom(),
                          "rand");
        end
        @(negedge clock);
        idleInputs();
        #1;
        checkOutput("final");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    // Safety net against a runaway simulation
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
